// File: rtl/sobel_pkg.sv
// ---------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel gradient post-processor.
//   mag_mode_e    : magnitude approximation select (code 3 is reserved and
//                   handled like MAG_MAXHALF by the datapath)
//   dir_e         : 4-sector quantised gradient direction
//   edge_class_e  : hysteresis edge class
//   TAN_NUM/SHIFT : tan(22.5 deg) ~= TAN_NUM / 2^TAN_SHIFT = 13/32
// ---------------------------------------------------------------------------
package sobel_pkg;

   typedef enum logic [1:0] {
      MAG_MAXHALF = 2'd0,
      MAG_L1      = 2'd1,
      MAG_MAX38   = 2'd2
   } mag_mode_e;

   typedef enum logic [1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      EDGE_NONE   = 2'd0,
      EDGE_WEAK   = 2'd1,
      EDGE_STRONG = 2'd2
   } edge_class_e;

   localparam int TAN_NUM   = 13;
   localparam int TAN_SHIFT = 5;

endpackage

// File: rtl/sobel_dir_quant.sv
// ---------------------------------------------------------------------------
// sobel_dir_quant
// Combinational 4-sector direction decision for non-max suppression.
// Ports:
//   i_gx13, i_gx32 : |gx|*13 and |gx|*32 (unsigned, PW bits)
//   i_gy13, i_gy32 : |gy|*13 and |gy|*32 (unsigned, PW bits)
//   i_sx, i_sy     : sign flags of the original gx / gy (1 = negative)
//   o_dir          : quantised direction
// ---------------------------------------------------------------------------
module sobel_dir_quant
   import sobel_pkg::*;
#(
   parameter int PW = 16
) (
   input  logic [PW-1:0] i_gx13,
   input  logic [PW-1:0] i_gx32,
   input  logic [PW-1:0] i_gy13,
   input  logic [PW-1:0] i_gy32,
   input  logic          i_sx,
   input  logic          i_sy,
   output dir_e          o_dir
);

   // Horizontal sector wins ties against the 22.5 deg line, so a zero
   // gradient lands in DIR_0. Diagonal sectors split on sign agreement.
   always_comb begin
      o_dir = DIR_0;
      if (i_gy32 <= i_gx13) begin
         o_dir = DIR_0;
      end else if (i_gy13 >= i_gx32) begin
         o_dir = DIR_90;
      end else if (i_sx == i_sy) begin
         o_dir = DIR_45;
      end else begin
         o_dir = DIR_135;
      end
   end

endmodule

// File: rtl/sobel_grad_pipe.sv
// ---------------------------------------------------------------------------
// sobel_grad_pipe
// Three-stage gradient post-processor between the Sobel convolution and
// non-max suppression. One sample per cycle, latency 3, no backpressure.
// Parameters:
//   NBIT : width of signed gx/gy inputs
//   MAGW : magnitude / threshold width, must be >= NBIT+1 so the L1 sum of
//          two full-scale negative inputs (2^NBIT) still fits
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_data_valid           : gx/gy/mode/thresholds valid this cycle
//   gx, gy                 : signed Sobel gradients
//   i_mode                 : magnitude approximation select (per sample)
//   i_thr_low, i_thr_high  : hysteresis thresholds (per sample)
//   o_data_valid           : outputs valid this cycle
//   module_g               : gradient magnitude
//   o_dir                  : quantised direction
//   o_edge_class           : hysteresis edge class
// ---------------------------------------------------------------------------
module sobel_grad_pipe
   import sobel_pkg::*;
#(
   parameter int NBIT = 11,
   parameter int MAGW = NBIT + 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_data_valid,
   input  logic signed [NBIT-1:0] gx,
   input  logic signed [NBIT-1:0] gy,
   input  logic [1:0]             i_mode,
   input  logic [MAGW-1:0]        i_thr_low,
   input  logic [MAGW-1:0]        i_thr_high,
   output logic                   o_data_valid,
   output logic [MAGW-1:0]        module_g,
   output logic [1:0]             o_dir,
   output logic [1:0]             o_edge_class
);

   localparam int PW = NBIT + 5;

   // ---------------- S1 ----------------
   logic [NBIT-1:0] w_ax;
   logic [NBIT-1:0] w_ay;

   // Negating the most negative value yields the same bit pattern, which read
   // as unsigned is exactly 2^(NBIT-1), so no wrap handling is needed.
   assign w_ax = gx[NBIT-1] ? $unsigned(-gx) : $unsigned(gx);
   assign w_ay = gy[NBIT-1] ? $unsigned(-gy) : $unsigned(gy);

   logic            r_v1;
   logic [NBIT-1:0] r_ax1;
   logic [NBIT-1:0] r_ay1;
   logic            r_sx1;
   logic            r_sy1;
   logic [1:0]      r_mode1;
   logic [MAGW-1:0] r_tl1;
   logic [MAGW-1:0] r_th1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1    <= 1'b0;
         r_ax1   <= '0;
         r_ay1   <= '0;
         r_sx1   <= 1'b0;
         r_sy1   <= 1'b0;
         r_mode1 <= '0;
         r_tl1   <= '0;
         r_th1   <= '0;
      end else begin
         r_v1 <= i_data_valid;
         if (i_data_valid) begin
            r_ax1   <= w_ax;
            r_ay1   <= w_ay;
            r_sx1   <= gx[NBIT-1];
            r_sy1   <= gy[NBIT-1];
            r_mode1 <= i_mode;
            r_tl1   <= i_thr_low;
            r_th1   <= i_thr_high;
         end
      end
   end

   // ---------------- S2 ----------------
   logic [NBIT-1:0] w_mx;
   logic [NBIT-1:0] w_mn;
   logic [PW-1:0]   w_gx13;
   logic [PW-1:0]   w_gx32;
   logic [PW-1:0]   w_gy13;
   logic [PW-1:0]   w_gy32;

   assign w_mx   = (r_ax1 >= r_ay1) ? r_ax1 : r_ay1;
   assign w_mn   = (r_ax1 >= r_ay1) ? r_ay1 : r_ax1;
   assign w_gx13 = PW'(r_ax1) * PW'(TAN_NUM);
   assign w_gy13 = PW'(r_ay1) * PW'(TAN_NUM);
   assign w_gx32 = PW'(r_ax1) << TAN_SHIFT;
   assign w_gy32 = PW'(r_ay1) << TAN_SHIFT;

   logic            r_v2;
   logic [NBIT-1:0] r_mx2;
   logic [NBIT-1:0] r_mn2;
   logic [NBIT-1:0] r_ax2;
   logic [NBIT-1:0] r_ay2;
   logic [PW-1:0]   r_gx13;
   logic [PW-1:0]   r_gx32;
   logic [PW-1:0]   r_gy13;
   logic [PW-1:0]   r_gy32;
   logic            r_sx2;
   logic            r_sy2;
   logic [1:0]      r_mode2;
   logic [MAGW-1:0] r_tl2;
   logic [MAGW-1:0] r_th2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v2    <= 1'b0;
         r_mx2   <= '0;
         r_mn2   <= '0;
         r_ax2   <= '0;
         r_ay2   <= '0;
         r_gx13  <= '0;
         r_gx32  <= '0;
         r_gy13  <= '0;
         r_gy32  <= '0;
         r_sx2   <= 1'b0;
         r_sy2   <= 1'b0;
         r_mode2 <= '0;
         r_tl2   <= '0;
         r_th2   <= '0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_mx2   <= w_mx;
            r_mn2   <= w_mn;
            r_ax2   <= r_ax1;
            r_ay2   <= r_ay1;
            r_gx13  <= w_gx13;
            r_gx32  <= w_gx32;
            r_gy13  <= w_gy13;
            r_gy32  <= w_gy32;
            r_sx2   <= r_sx1;
            r_sy2   <= r_sy1;
            r_mode2 <= r_mode1;
            r_tl2   <= r_tl1;
            r_th2   <= r_th1;
         end
      end
   end

   // ---------------- S3 ----------------
   logic [MAGW-1:0] w_mxE;
   logic [MAGW-1:0] w_mnE;
   logic [MAGW-1:0] w_mag;
   edge_class_e     w_cls;
   dir_e            w_dir;

   assign w_mxE = MAGW'(r_mx2);
   assign w_mnE = MAGW'(r_mn2);

   // Mode 3 is reserved and falls through to the max + min/2 approximation.
   always_comb begin
      w_mag = w_mxE + (w_mnE >> 1);
      case (r_mode2)
         MAG_L1:    w_mag = MAGW'(r_ax2) + MAGW'(r_ay2);
         MAG_MAX38: w_mag = w_mxE + (w_mnE >> 2) + (w_mnE >> 3);
         default:   w_mag = w_mxE + (w_mnE >> 1);
      endcase
   end

   // Strong test first, so an inverted threshold pair still reports strong.
   always_comb begin
      w_cls = EDGE_NONE;
      if (w_mag >= r_th2) begin
         w_cls = EDGE_STRONG;
      end else if (w_mag >= r_tl2) begin
         w_cls = EDGE_WEAK;
      end
   end

   sobel_dir_quant #(
      .PW (PW)
   ) u_dir_quant (
      .i_gx13 (r_gx13),
      .i_gx32 (r_gx32),
      .i_gy13 (r_gy13),
      .i_gy32 (r_gy32),
      .i_sx   (r_sx2),
      .i_sy   (r_sy2),
      .o_dir  (w_dir)
   );

   logic            r_v3;
   logic [MAGW-1:0] r_mag3;
   dir_e            r_dir3;
   edge_class_e     r_cls3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v3   <= 1'b0;
         r_mag3 <= '0;
         r_dir3 <= DIR_0;
         r_cls3 <= EDGE_NONE;
      end else begin
         r_v3 <= r_v2;
         if (r_v2) begin
            r_mag3 <= w_mag;
            r_dir3 <= w_dir;
            r_cls3 <= w_cls;
         end
      end
   end

   assign o_data_valid = r_v3;
   assign module_g     = r_mag3;
   assign o_dir        = r_dir3;
   assign o_edge_class = r_cls3;

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// ---------------------------------------------------------------------------
// tb_sobel_grad_pipe
// Self-checking bench for sobel_grad_pipe. A reference model computes each
// sample's expected magnitude, direction and class from plain integer
// arithmetic; a short queue delays those expectations by the pipeline depth.
// ---------------------------------------------------------------------------
module tb_sobel_grad_pipe;

   localparam int NBIT = 11;
   localparam int MAGW = NBIT + 1;

   logic                   clk     = 1'b0;
   logic                   rst_n   = 1'b0;
   logic                   inValid = 1'b0;
   logic signed [NBIT-1:0] gx      = '0;
   logic signed [NBIT-1:0] gy      = '0;
   logic [1:0]             mode    = '0;
   logic [MAGW-1:0]        thrLow  = '0;
   logic [MAGW-1:0]        thrHigh = '0;
   logic                   outValid;
   logic [MAGW-1:0]        magOut;
   logic [1:0]             dirOut;
   logic [1:0]             clsOut;

   sobel_grad_pipe #(
      .NBIT (NBIT),
      .MAGW (MAGW)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_data_valid (inValid),
      .gx           (gx),
      .gy           (gy),
      .i_mode       (mode),
      .i_thr_low    (thrLow),
      .i_thr_high   (thrHigh),
      .o_data_valid (outValid),
      .module_g     (magOut),
      .o_dir        (dirOut),
      .o_edge_class (clsOut)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit v;
      int mag;
      int dir;
      int cls;
   } exp_t;

   exp_t pipe[$];
   bit   expV;
   int   expMag;
   int   expDir;
   int   expCls;
   int   nCompared = 0;
   int   nFailed   = 0;

   // Behavioural reference: magnitude approximations, sector rule with
   // tan(22.5) ~= 13/32, and strong-first hysteresis classification.
   function automatic exp_t refModel(input bit v, input int sgx, input int sgy,
                                     input int smode, input int tl, input int th);
      exp_t e;
      int ax, ay, mx, mn;
      ax = (sgx < 0) ? -sgx : sgx;
      ay = (sgy < 0) ? -sgy : sgy;
      mx = (ax > ay) ? ax : ay;
      mn = (ax > ay) ? ay : ax;
      e.v = v;
      case (smode)
         1:       e.mag = ax + ay;
         2:       e.mag = mx + mn / 4 + mn / 8;
         default: e.mag = mx + mn / 2;
      endcase
      if (ay * 32 <= ax * 13)              e.dir = 0;
      else if (ay * 13 >= ax * 32)         e.dir = 2;
      else if ((sgx < 0) == (sgy < 0))     e.dir = 1;
      else                                 e.dir = 3;
      if (e.mag >= th)      e.cls = 2;
      else if (e.mag >= tl) e.cls = 1;
      else                  e.cls = 0;
      return e;
   endfunction

   task automatic resetModel();
      exp_t e;
      e.v = 1'b0; e.mag = 0; e.dir = 0; e.cls = 0;
      pipe.delete();
      pipe.push_back(e);
      pipe.push_back(e);
      expV = 1'b0; expMag = 0; expDir = 0; expCls = 0;
   endtask

   // Drives one cycle of input, clocks it in and advances the expectations.
   task automatic applyStimulus(input bit v, input int sgx, input int sgy,
                                input int smode, input int tl, input int th);
      exp_t e;
      inValid = v;
      gx      = NBIT'(sgx);
      gy      = NBIT'(sgy);
      mode    = 2'(smode);
      thrLow  = MAGW'(tl);
      thrHigh = MAGW'(th);
      e = refModel(v, sgx, sgy, smode, tl, th);
      @(posedge clk);
      #1;
      pipe.push_back(e);
      e = pipe.pop_front();
      expV = e.v;
      if (e.v) begin
         expMag = e.mag; expDir = e.dir; expCls = e.cls;
      end
   endtask

   function automatic int rndG();
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      nCompared += 4;
      if (outValid !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_valid: got %0b expected 0", outValid); end
      if (magOut !== '0)     begin nFailed++; $display("[TB] FAIL reset_mag: got %0d expected 0", magOut); end
      if (dirOut !== 2'd0)   begin nFailed++; $display("[TB] FAIL reset_dir: got %0d expected 0", dirOut); end
      if (clsOut !== 2'd0)   begin nFailed++; $display("[TB] FAIL reset_cls: got %0d expected 0", clsOut); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      resetModel();
   endtask

   // Isolated samples with hand-computed results, also checking latency.
   task automatic test_directed();
      int tGx[8]  = '{300, 300, 300, -1024, -1024, 10, 100, 0};
      int tGy[8]  = '{-100, -100, -100, -1024, -1024, -200, -100, 0};
      int tMd[8]  = '{0, 1, 2, 0, 1, 0, 0, 0};
      int tMag[8] = '{350, 400, 337, 1536, 2048, 205, 150, 0};
      int tDir[8] = '{0, 0, 0, 1, 1, 2, 3, 0};
      int tCls[8] = '{2, 2, 2, 2, 2, 1, 1, 0};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, tGx[i], tGy[i], tMd[i], 100, 300);
         applyStimulus(1'b0, rndG(), rndG(), 3, 0, 0);
         nCompared++;
         if (outValid !== 1'b0) begin nFailed++; $display("[TB] FAIL directed%0d_early_valid: got %0b expected 0", i, outValid); end
         applyStimulus(1'b0, rndG(), rndG(), 3, 0, 0);
         nCompared += 4;
         if (outValid !== 1'b1)          begin nFailed++; $display("[TB] FAIL directed%0d_valid: got %0b expected 1", i, outValid); end
         if (magOut !== MAGW'(tMag[i]))  begin nFailed++; $display("[TB] FAIL directed%0d_mag: got %0d expected %0d", i, magOut, tMag[i]); end
         if (dirOut !== 2'(tDir[i]))     begin nFailed++; $display("[TB] FAIL directed%0d_dir: got %0d expected %0d", i, dirOut, tDir[i]); end
         if (clsOut !== 2'(tCls[i]))     begin nFailed++; $display("[TB] FAIL directed%0d_cls: got %0d expected %0d", i, clsOut, tCls[i]); end
      end
   endtask

   // Eight samples with a bubble after the fourth, mode changing per sample.
   task automatic test_back_to_back();
      int vld[12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
      int s = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vld[i] != 0, rndG(), rndG(), s % 3, 200, 900);
         if (vld[i] != 0) s++;
         nCompared += 4;
         if (outValid !== expV)          begin nFailed++; $display("[TB] FAIL b2b%0d_valid: got %0b expected %0b", i, outValid, expV); end
         if (magOut !== MAGW'(expMag))   begin nFailed++; $display("[TB] FAIL b2b%0d_mag: got %0d expected %0d", i, magOut, expMag); end
         if (dirOut !== 2'(expDir))      begin nFailed++; $display("[TB] FAIL b2b%0d_dir: got %0d expected %0d", i, dirOut, expDir); end
         if (clsOut !== 2'(expCls))      begin nFailed++; $display("[TB] FAIL b2b%0d_cls: got %0d expected %0d", i, clsOut, expCls); end
      end
   endtask

   // Magnitudes straddling each threshold, then an inverted threshold pair.
   task automatic test_thresholds();
      int tMag[5] = '{149, 150, 349, 350, 300};
      int tLow[5] = '{150, 150, 150, 150, 400};
      int tHi[5]  = '{350, 350, 350, 350, 200};
      int tCls[5] = '{0, 1, 1, 2, 2};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, tMag[i], 0, 1, tLow[i], tHi[i]);
         applyStimulus(1'b0, 0, 0, 0, 0, 0);
         applyStimulus(1'b0, 0, 0, 0, 0, 0);
         nCompared += 3;
         if (outValid !== 1'b1)         begin nFailed++; $display("[TB] FAIL thr%0d_valid: got %0b expected 1", i, outValid); end
         if (magOut !== MAGW'(tMag[i])) begin nFailed++; $display("[TB] FAIL thr%0d_mag: got %0d expected %0d", i, magOut, tMag[i]); end
         if (clsOut !== 2'(tCls[i]))    begin nFailed++; $display("[TB] FAIL thr%0d_cls: got %0d expected %0d", i, clsOut, tCls[i]); end
      end
   endtask

   task automatic test_random();
      int a, b;
      for (int i = 0; i < 300; i++) begin
         a = rndG();
         b = rndG();
         if ($urandom_range(0, 15) == 0) a = -1024;
         if ($urandom_range(0, 15) == 0) b = 1023;
         applyStimulus($urandom_range(0, 3) != 0, a, b, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 2500)), int'($urandom_range(0, 2500)));
         nCompared += 4;
         if (outValid !== expV)        begin nFailed++; $display("[TB] FAIL rand%0d_valid: got %0b expected %0b", i, outValid, expV); end
         if (magOut !== MAGW'(expMag)) begin nFailed++; $display("[TB] FAIL rand%0d_mag: got %0d expected %0d", i, magOut, expMag); end
         if (dirOut !== 2'(expDir))    begin nFailed++; $display("[TB] FAIL rand%0d_dir: got %0d expected %0d", i, dirOut, expDir); end
         if (clsOut !== 2'(expCls))    begin nFailed++; $display("[TB] FAIL rand%0d_cls: got %0d expected %0d", i, clsOut, expCls); end
      end
   endtask

   // Reset between edges with samples in flight, then a fresh sample.
   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 500, -300, 0, 100, 300);
      inValid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      nCompared += 4;
      if (outValid !== 1'b0) begin nFailed++; $display("[TB] FAIL arst_valid: got %0b expected 0", outValid); end
      if (magOut !== '0)     begin nFailed++; $display("[TB] FAIL arst_mag: got %0d expected 0", magOut); end
      if (dirOut !== 2'd0)   begin nFailed++; $display("[TB] FAIL arst_dir: got %0d expected 0", dirOut); end
      if (clsOut !== 2'd0)   begin nFailed++; $display("[TB] FAIL arst_cls: got %0d expected 0", clsOut); end
      resetModel();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i == 3, 100, -100, 0, 100, 300);
         nCompared++;
         if (outValid !== expV) begin nFailed++; $display("[TB] FAIL arst_post%0d_valid: got %0b expected %0b", i, outValid, expV); end
         if (i == 5) begin
            nCompared += 3;
            if (outValid !== 1'b1)   begin nFailed++; $display("[TB] FAIL arst_first_valid: got %0b expected 1", outValid); end
            if (magOut !== MAGW'(150)) begin nFailed++; $display("[TB] FAIL arst_first_mag: got %0d expected 150", magOut); end
            if (dirOut !== 2'd3)     begin nFailed++; $display("[TB] FAIL arst_first_dir: got %0d expected 3", dirOut); end
         end
      end
   endtask

   initial begin
      resetModel();
      test_reset();
      test_directed();
      test_back_to_back();
      test_thresholds();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
